// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified RAM/IO port arbiter: FSM states, LSB op
// field encoding and default IO addresses.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIfetch = 2'd1,
      StLoad   = 2'd2,
      StStore  = 2'd3
   } arb_state_e;

   // lsb_op[1:0] access size
   typedef enum logic [1:0] {
      LsbByte = 2'b00,
      LsbHalf = 2'b01,
      LsbWord = 2'b10
   } lsb_size_e;

   localparam int unsigned LsbOpStore    = 3;
   localparam int unsigned LsbOpUnsigned = 2;

   localparam logic [31:0] IoAddrDefault  = 32'h0003_0000;
   localparam logic [31:0] IoAddr2Default = 32'h0003_0004;

   function automatic logic [2:0] size_bytes(input lsb_size_e sz);
      case (sz)
         LsbByte: return 3'd1;
         LsbHalf: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the arbiter: byte counter, address increment, read-byte
// assembly, store-byte select and load extension.
module mem_byte_seq
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned AddrW = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             start_i,
   input  logic [AddrW-1:0] base_i,
   input  logic [31:0]      wdata_i,
   input  lsb_size_e        size_i,
   input  logic             uns_i,
   input  logic             step_i,
   input  logic [7:0]       mem_din_i,
   output logic [2:0]       cnt_o,
   output logic [2:0]       nbytes_o,
   output logic [AddrW-1:0] nxt_addr_o,
   output logic [7:0]       nxt_byte_o,
   output logic [31:0]      rd_word_o
);

   logic [AddrW-1:0] base_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rbuf_q;
   lsb_size_e        size_q;
   logic             uns_q;
   logic [2:0]       cnt_q;

   logic [1:0]  widx;
   logic [1:0]  ridx;
   logic [31:0] merged;

   // Byte selection and little-endian merge of the byte arriving on mem_din.
   // The byte on mem_din lags the counter by one (RAM read latency).
   always_comb begin
      widx       = cnt_q[1:0] + 2'd1;
      ridx       = cnt_q[1:0] - 2'd1;
      merged     = rbuf_q;
      merged[{ridx, 3'b000} +: 8] = mem_din_i;
      nxt_byte_o = wdata_q[{widx, 3'b000} +: 8];
      nxt_addr_o = base_q + AddrW'(cnt_q) + AddrW'(1);
      nbytes_o   = size_bytes(size_q);
      cnt_o      = cnt_q;
   end

   // Sign/zero extension of the assembled load word.
   always_comb begin
      case (size_q)
         LsbByte: rd_word_o = uns_q ? {24'h0, merged[7:0]} : {{24{merged[7]}}, merged[7:0]};
         LsbHalf: rd_word_o = uns_q ? {16'h0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
         default: rd_word_o = merged;
      endcase
   end

   // Transfer context and counter; frozen while en_i is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         size_q  <= LsbByte;
         uns_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (en_i) begin
         if (start_i) begin
            base_q  <= base_i;
            wdata_q <= wdata_i;
            rbuf_q  <= '0;
            size_q  <= size_i;
            uns_q   <= uns_i;
            cnt_q   <= '0;
         end else if (step_i) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q != 3'd0) rbuf_q <= merged;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the byte-wide unified RAM/IO port shared by instruction fetch
// and the LSB. Optional round-robin grant: define MEM_ARB_RR_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] IO_ADDR  = ADDR_W'(IoAddrDefault),
   parameter logic [ADDR_W-1:0] IO_ADDR2 = ADDR_W'(IoAddr2Default)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_flag,
   input  logic              io_buffer_full,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [31:0]       if_data,
   input  logic              lsb_req,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [31:0]       lsb_data,
   input  logic [3:0]        lsb_op,
   output logic              lsb_ready,
   output logic [31:0]       lsb_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);

   arb_state_e        state_q, state_d;
   logic              if_ready_q, if_ready_d;
   logic              lsb_ready_q, lsb_ready_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       lsb_rdata_q, lsb_rdata_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic              mem_wr_q, mem_wr_d;

   logic              lsb_ok, if_ok, grant_lsb, grant_if;
   logic              seq_start, seq_step;
   logic [2:0]        cnt, nbytes;
   logic [ADDR_W-1:0] nxt_addr, seq_base;
   logic [7:0]        nxt_byte;
   logic [31:0]       rd_word;
   lsb_size_e         seq_size;
   logic              seq_uns;
   logic              rd_done, st_last;

   function automatic logic io_hit(input logic [ADDR_W-1:0] a);
      return (a == IO_ADDR) || (a == IO_ADDR2);
   endfunction

   // A requester still held during its own ready cycle must not be re-accepted.
   assign lsb_ok = lsb_req & ~lsb_ready_q & ~clear_flag;
   assign if_ok  = if_req & ~if_ready_q & ~clear_flag;

`ifdef MEM_ARB_RR_EN
   logic rr_lsb_q, rr_lsb_d;  // 1: LSB wins the next contention

   assign grant_lsb = (lsb_ok & if_ok) ? rr_lsb_q : lsb_ok;
   assign grant_if  = if_ok & ~grant_lsb;

   // Pointer flips to the other requester at every accept.
   always_comb begin
      rr_lsb_d = rr_lsb_q;
      if (state_q == StIdle && (grant_lsb || grant_if)) rr_lsb_d = grant_if;
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)     rr_lsb_q <= 1'b1;
      else if (rdy_in) rr_lsb_q <= rr_lsb_d;
   end
`else
   assign grant_lsb = lsb_ok;
   assign grant_if  = if_ok & ~lsb_req;
`endif

   assign seq_base = grant_lsb ? lsb_addr : if_addr;
   assign seq_size = grant_lsb ? lsb_size_e'(lsb_op[1:0]) : LsbWord;
   assign seq_uns  = grant_lsb ? lsb_op[LsbOpUnsigned] : 1'b1;
   assign rd_done  = (cnt == nbytes);
   assign st_last  = (cnt == nbytes - 3'd1);

   mem_byte_seq #(
      .AddrW (ADDR_W)
   ) u_seq (
      .clk_i      (clk_in),
      .rst_ni     (rst_in),
      .en_i       (rdy_in),
      .start_i    (seq_start),
      .base_i     (seq_base),
      .wdata_i    (lsb_data),
      .size_i     (seq_size),
      .uns_i      (seq_uns),
      .step_i     (seq_step),
      .mem_din_i  (mem_din),
      .cnt_o      (cnt),
      .nbytes_o   (nbytes),
      .nxt_addr_o (nxt_addr),
      .nxt_byte_o (nxt_byte),
      .rd_word_o  (rd_word)
   );

   // State and registered outputs; everything holds while rdy_in is low.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= StIdle;
         if_ready_q  <= 1'b0;
         lsb_ready_q <= 1'b0;
         if_data_q   <= '0;
         lsb_rdata_q <= '0;
         mem_dout_q  <= '0;
         mem_a_q     <= '0;
         mem_wr_q    <= 1'b0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         if_ready_q  <= if_ready_d;
         lsb_ready_q <= lsb_ready_d;
         if_data_q   <= if_data_d;
         lsb_rdata_q <= lsb_rdata_d;
         mem_dout_q  <= mem_dout_d;
         mem_a_q     <= mem_a_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   // Next-state: accept, read completion/flush, store completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (grant_lsb)     state_d = lsb_op[LsbOpStore] ? StStore : StLoad;
            else if (grant_if) state_d = StIfetch;
         end
         StIfetch, StLoad: if (clear_flag || rd_done) state_d = StIdle;
         StStore:          if (mem_wr_q && st_last)   state_d = StIdle;
         default:          state_d = StIdle;
      endcase
   end

   // Output next values and sequencer strobes.
   always_comb begin
      if_ready_d  = 1'b0;
      lsb_ready_d = 1'b0;
      if_data_d   = if_data_q;
      lsb_rdata_d = lsb_rdata_q;
      mem_dout_d  = mem_dout_q;
      mem_a_d     = mem_a_q;
      mem_wr_d    = mem_wr_q;
      seq_start   = 1'b0;
      seq_step    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_lsb || grant_if) begin
               seq_start = 1'b1;
               mem_a_d   = seq_base;
               mem_wr_d  = 1'b0;
               if (grant_lsb && lsb_op[LsbOpStore]) begin
                  mem_dout_d = lsb_data[7:0];
                  mem_wr_d   = ~(io_hit(lsb_addr) & io_buffer_full);
               end
            end
         end
         StIfetch, StLoad: begin
            if (clear_flag) begin
               mem_a_d  = '0;
               mem_wr_d = 1'b0;
            end else if (rd_done) begin
               mem_a_d = '0;
               if (state_q == StIfetch) begin
                  if_ready_d = 1'b1;
                  if_data_d  = rd_word;
               end else begin
                  lsb_ready_d = 1'b1;
                  lsb_rdata_d = rd_word;
               end
            end else begin
               seq_step = 1'b1;
               if (cnt < nbytes - 3'd1) mem_a_d = nxt_addr;
            end
         end
         StStore: begin
            if (!mem_wr_q) begin
               // Stalled on a full UART buffer: retry the same byte.
               mem_wr_d = ~(io_hit(mem_a_q) & io_buffer_full);
            end else if (st_last) begin
               lsb_ready_d = 1'b1;
               lsb_rdata_d = '0;
               mem_wr_d    = 1'b0;
               mem_a_d     = '0;
            end else begin
               seq_step   = 1'b1;
               mem_a_d    = nxt_addr;
               mem_dout_d = nxt_byte;
               mem_wr_d   = ~(io_hit(nxt_addr) & io_buffer_full);
            end
         end
         default: ;
      endcase
   end

   assign if_ready  = if_ready_q;
   assign lsb_ready = lsb_ready_q;
   assign if_data   = if_data_q;
   assign lsb_rdata = lsb_rdata_q;
   assign mem_dout  = mem_dout_q;
   assign mem_a     = mem_a_q;
   assign mem_wr    = mem_wr_q;

endmodule
